// File: rtl/fmul_hp_arbiter.sv
// Two-requester round-robin front end for one fixed-latency pipelined fp16 multiplier.
// Optional sticky exception flags per requester: define FMUL_ARB_STICKY_EXC_EN.
module fmul_hp_arbiter #(
    parameter int FMUL_LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_op_a,
    input  logic [15:0] req0_op_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_op_a,
    input  logic [15:0] req1_op_b,
    output logic        res0_valid,
    output logic [15:0] res0_data,
    output logic        res0_ovf,
    output logic        res0_unf,
    output logic        res1_valid,
    output logic [15:0] res1_data,
    output logic        res1_ovf,
    output logic        res1_unf,
    output logic        fmul_sign_1,
    output logic [4:0]  fmul_exp_1,
    output logic [9:0]  fmul_man_1,
    output logic        fmul_sign_2,
    output logic [4:0]  fmul_exp_2,
    output logic [9:0]  fmul_man_2,
    input  logic        fmul_sign,
    input  logic [4:0]  fmul_exp,
    input  logic [9:0]  fmul_man,
    input  logic        fmul_ovf,
    input  logic        fmul_unf,
`ifdef FMUL_ARB_STICKY_EXC_EN
    input  logic        exc_clear0,
    input  logic        exc_clear1,
    output logic [1:0]  exc_sticky0,
    output logic [1:0]  exc_sticky1,
`endif
    output logic        busy
);

    // Handshake: a requester's operands are consumed on a rising edge where
    // reqN_valid && reqN_ready; at most one ready is high in any cycle.
    localparam int DEPTH = FMUL_LATENCY + 1;

    logic             r_rr_last;
    logic [DEPTH-1:0] r_tag_v;
    logic [DEPTH-1:0] r_tag_id;
    logic [15:0]      r_op_1;
    logic [15:0]      r_op_2;
    logic             r_res0_valid;
    logic [15:0]      r_res0_data;
    logic             r_res0_ovf;
    logic             r_res0_unf;
    logic             r_res1_valid;
    logic [15:0]      r_res1_data;
    logic             r_res1_ovf;
    logic             r_res1_unf;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_issue;
    logic [15:0]      w_op_a;
    logic [15:0]      w_op_b;
    logic [15:0]      w_res;
    logic             w_out_v;
    logic             w_out_id;

    // Contention goes to whoever was not granted last.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!reset) begin
            w_grant0 = req0_valid && (!req1_valid || r_rr_last);
            w_grant1 = req1_valid && (!req0_valid || !r_rr_last);
        end
    end

    always_comb begin
        w_op_a = 16'h0000;
        w_op_b = 16'h0000;
        if (w_grant0) begin
            w_op_a = req0_op_a;
            w_op_b = req0_op_b;
        end else if (w_grant1) begin
            w_op_a = req1_op_a;
            w_op_b = req1_op_b;
        end
    end

    assign w_issue  = w_grant0 | w_grant1;
    assign w_res    = {fmul_sign, fmul_exp, fmul_man};
    assign w_out_v  = r_tag_v[DEPTH-1];
    assign w_out_id = r_tag_id[DEPTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_last    <= 1'b1;
            r_tag_v      <= '0;
            r_tag_id     <= '0;
            r_op_1       <= 16'h0000;
            r_op_2       <= 16'h0000;
            r_res0_valid <= 1'b0;
            r_res0_data  <= 16'h0000;
            r_res0_ovf   <= 1'b0;
            r_res0_unf   <= 1'b0;
            r_res1_valid <= 1'b0;
            r_res1_data  <= 16'h0000;
            r_res1_ovf   <= 1'b0;
            r_res1_unf   <= 1'b0;
        end else begin
            r_op_1   <= w_op_a;
            r_op_2   <= w_op_b;
            r_tag_v  <= {r_tag_v[DEPTH-2:0], w_issue};
            r_tag_id <= {r_tag_id[DEPTH-2:0], w_grant1};
            if (w_issue) begin
                r_rr_last <= w_grant1;
            end
            r_res0_valid <= w_out_v && !w_out_id;
            r_res1_valid <= w_out_v && w_out_id;
            // Result fields only move for the owning requester; the other holds.
            if (w_out_v && !w_out_id) begin
                r_res0_data <= w_res;
                r_res0_ovf  <= fmul_ovf;
                r_res0_unf  <= fmul_unf;
            end
            if (w_out_v && w_out_id) begin
                r_res1_data <= w_res;
                r_res1_ovf  <= fmul_ovf;
                r_res1_unf  <= fmul_unf;
            end
        end
    end

`ifdef FMUL_ARB_STICKY_EXC_EN
    logic [1:0] r_sticky0;
    logic [1:0] r_sticky1;

    // A flag delivered in the same cycle as a clear survives the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sticky0 <= 2'b00;
            r_sticky1 <= 2'b00;
        end else begin
            r_sticky0 <= (exc_clear0 ? 2'b00 : r_sticky0)
                         | ({r_res0_ovf, r_res0_unf} & {2{r_res0_valid}});
            r_sticky1 <= (exc_clear1 ? 2'b00 : r_sticky1)
                         | ({r_res1_ovf, r_res1_unf} & {2{r_res1_valid}});
        end
    end

    assign exc_sticky0 = r_sticky0;
    assign exc_sticky1 = r_sticky1;
`endif

    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;
    assign res0_valid  = r_res0_valid;
    assign res0_data   = r_res0_data;
    assign res0_ovf    = r_res0_ovf;
    assign res0_unf    = r_res0_unf;
    assign res1_valid  = r_res1_valid;
    assign res1_data   = r_res1_data;
    assign res1_ovf    = r_res1_ovf;
    assign res1_unf    = r_res1_unf;
    assign fmul_sign_1 = r_op_1[15];
    assign fmul_exp_1  = r_op_1[14:10];
    assign fmul_man_1  = r_op_1[9:0];
    assign fmul_sign_2 = r_op_2[15];
    assign fmul_exp_2  = r_op_2[14:10];
    assign fmul_man_2  = r_op_2[9:0];
    assign busy        = (|r_tag_v) | r_res0_valid | r_res1_valid;

endmodule

// File: doc/fmul_hp_arbiter.md
Name: fmul_hp_arbiter

Overview:
Shares one pipelined half-precision floating-point multiplier (FMul_HalfPrecision_Pipelined, fixed latency, no stall) between two requesters. Each requester uses a valid/ready handshake. Arbitration is round-robin with at most one issue per cycle. A tag pipeline, matched to the multiplier depth, routes each result and its exception flags back to the requester that issued it. The block sits between client datapaths and the multiplier instance.

Parameters:
FMUL_LATENCY, 3, multiplier pipeline depth in cycles from operand ports to result ports; must be 1 to 8.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state; tie the same net to the multiplier reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 is granted this cycle
req0_op_a  input  16  operand A {sign, exp[4:0], man[9:0]}
req0_op_b  input  16  operand B, same packing
req1_valid, req1_ready, req1_op_a, req1_op_b  as requester 0
res0_valid  output  1  one-cycle pulse: result for requester 0
res0_data  output  16  result {sign, exp, man}
res0_ovf  output  1  exponent overflow for this result
res0_unf  output  1  exponent underflow for this result
res1_valid, res1_data, res1_ovf, res1_unf  as requester 0
fmul_sign_1  output  1  multiplier operand 1 sign
fmul_exp_1  output  5  multiplier operand 1 exponent
fmul_man_1  output  10  multiplier operand 1 mantissa
fmul_sign_2, fmul_exp_2, fmul_man_2  output  1/5/10  multiplier operand 2 fields
fmul_sign  input  1  multiplier result sign
fmul_exp  input  5  multiplier result exponent
fmul_man  input  10  multiplier result mantissa
fmul_ovf  input  1  multiplier Exponent_Overflow
fmul_unf  input  1  multiplier Exponent_Underflow
busy  output  1  high while any issued operation is in flight

Behaviour:
- Reset values: all ready, res_valid and busy outputs 0; res data and flags 0; fmul operand outputs 0; tag pipeline empty; rr_last = 1, so requester 0 wins first.
- Grant logic is combinational from valid and rr_last:
  - Only one valid: that requester gets ready = 1.
  - Both valid: the requester not equal to rr_last gets ready.
  - Neither valid: both ready = 0.
  - req0_ready and req1_ready are never high together.
  - Ready is also forced 0 while reset is high.
- Issue: on a cycle with valid && ready:
  - The operands are registered onto the fmul_* ports.
  - Entry {v=1, tag=grantee} is pushed into tag stage 0.
  - rr_last is set to the grantee.
- No issue: fmul_* ports are driven 0 (+0 × +0) and stage 0 is pushed with v=0. rr_last holds.
- Tag pipeline is FMUL_LATENCY+1 stages deep and shifts every cycle unconditionally; the multiplier never stalls.
- Latency: an op issued (handshake) at edge N produces res*_valid high during the cycle after edge N+FMUL_LATENCY+1. Default: 4 cycles issue-to-result.
- On output: when the final stage has v=1, result fields, ovf and unf are registered onto the tag's res* outputs and that res*_valid pulses for 1 cycle.
  - The other requester's res_valid stays 0.
  - Its res_data holds its last value.
- No result backpressure; requesters must accept a result every cycle.
- Throughput: 1 issue per cycle sustained. With both requesters continuously valid, grants alternate 0,1,0,1…
- busy = OR of v over all tag stages and the output register.
- Reset mid-operation: all in-flight tags are discarded. No res_valid for ops issued before reset; the first new result appears only after a fresh issue.
- An operand change while valid && !ready has no effect; the operand is sampled only on handshake.

Optional Feature:
FMUL_ARB_STICKY_EXC_EN
- Defined:
  - Adds inputs exc_clear0 and exc_clear1 (1 bit each).
  - Adds outputs exc_sticky0[1:0] and exc_sticky1[1:0], packed {ovf, unf}.
  - Each bit sets when the matching res*_ovf or res*_unf is delivered with res*_valid.
  - exc_clear* clears the requester's flags at the next edge; a simultaneous set wins over clear.
  - Reset clears all sticky flags.
- Undefined: these ports and registers are absent; per-result flags are unchanged.

Test Plan:
- Single op: req0 issues 0x3C00 × 0x4000 (1.0×2.0) → res0_valid 4 cycles later, res0_data 0x4000, ovf=unf=0, res1_valid never high.
- Contention: both valid for 4 cycles; req0 3C00×4200, req1 4200×C000 → grant order 0,1,0,1. Results alternate with res0_data 0x4200 and res1_data 0xC600 (-6.0), each 4 cycles after its grant.
- Back-to-back single requester: req1 valid for 6 consecutive cycles → ready high every cycle, 6 consecutive res1_valid pulses in order, busy high throughout.
- Exceptions: req0 issues 0x7800 × 0x7800 → res0_ovf=1. req0 issues 0x0400 × 0x0400 → res0_unf=1. With FMUL_ARB_STICKY_EXC_EN, exc_sticky0 = 2'b11 until exc_clear0.
- Reset mid-flight: issue 2 ops, assert reset 1 cycle later for 1 cycle → no res_valid pulses for the next 8 cycles, busy=0 after reset, rr_last back to 1.
- Idle: no valid for 10 cycles → ready low, fmul_* operands 0, no res_valid.
